// File: rtl/pf_pkg.sv
// Shared definitions for the playfield tile fetch path.
//   PF_COLS / PF_ROWS : playfield geometry in tiles
//   TILE_W            : tile width/height in pixels (one fetch slot per tile)
//   pf_state_e        : fetch sequencer states
//   lane_mask()       : column low bits -> active-low RAM byte-lane enable
package pf_pkg;

  localparam int unsigned PF_COLS = 32;
  localparam int unsigned PF_ROWS = 30;
  localparam int unsigned TILE_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    RUN      = 2'd2
  } pf_state_e;

  // Four tile codes share one 32-bit RAM word; col[1:0] picks the byte lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] col);
    lane_mask = ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/pf_shifter.sv
// Two-plane 8-bit pixel shifter.
//   clk_a, reset : clock, synchronous active-high reset
//   clear        : synchronous clear (line restart)
//   load         : load d0/d1 (tile boundary); has priority over shift
//   shift        : advance one pixel
//   flip         : 0 = shift left, MSB out; 1 = shift right, LSB out
//   d0, d1       : bitplane 0 / bitplane 1 load data
//   pix          : current pixel {plane1, plane0}
module pf_shifter (
  input  logic       clk_a,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       shift,
  input  logic       flip,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output logic [1:0] pix
);

  logic [7:0] sh0_q, sh1_q;

  always_ff @(posedge clk_a) begin
    if (reset || clear) begin
      sh0_q <= 8'h00;
      sh1_q <= 8'h00;
    end else if (load) begin
      sh0_q <= d0;
      sh1_q <= d1;
    end else if (shift) begin
      if (flip) begin
        sh0_q <= {1'b0, sh0_q[7:1]};
        sh1_q <= {1'b0, sh1_q[7:1]};
      end else begin
        sh0_q <= {sh0_q[6:0], 1'b0};
        sh1_q <= {sh1_q[6:0], 1'b0};
      end
    end
  end

  always_comb begin
    pix = flip ? {sh1_q[0], sh0_q[0]} : {sh1_q[7], sh0_q[7]};
  end

endmodule

// File: rtl/pf_tile_fetch.sv
// Playfield tile fetch and serializer.
// Reads tile codes from the playfield RAM word port, fetches both bitplanes of
// the current tile line from the graphics ROM and shifts out one pixel per
// pix_ce. One tile is fetched ahead of the tile being displayed.
//   clk_a, reset           : clock, synchronous active-high reset
//   pix_ce                 : pixel enable (at most every second clk_a)
//   line_start, vpos,
//   flip, gfx_bank         : line request, sampled with pix_ce
//   pf_addr, pf_ce         : playfield RAM word address / active-low lane enable
//   pf_dout                : playfield RAM word (combinational read)
//   rom_addr               : graphics ROM address {bank, code[5:0], line}
//   rom_d0, rom_d1         : graphics ROM bitplanes (1 clk_a latency)
//   pix, pix_attr          : pixel colour index / tile attribute
//   pix_valid, busy        : active pixel output / line in progress
module pf_tile_fetch
  import pf_pkg::*;
(
  input  logic        clk_a,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        line_start,
  input  logic [7:0]  vpos,
  input  logic        flip,
  input  logic        gfx_bank,
  output logic [7:0]  pf_addr,
  output logic [3:0]  pf_ce,
  input  logic [31:0] pf_dout,
  output logic [9:0]  rom_addr,
  input  logic [7:0]  rom_d0,
  input  logic [7:0]  rom_d1,
  output logic [1:0]  pix,
  output logic [1:0]  pix_attr,
  output logic        pix_valid,
  output logic        busy
);

  pf_state_e  state_q;
  logic [2:0] p_q;
  logic [5:0] c_q;
  logic [4:0] row_q;
  logic [2:0] line_q;
  logic       flip_q;
  logic       bank_q;
  logic [7:0] code_q;
  logic [7:0] pend0_q, pend1_q;
  logic [1:0] pend_attr_q;
  logic [1:0] attr_q;

  logic       restart;
  logic       step;
  logic       tile_end;
  logic       blank;
  logic       fetch_en;
  logic       run;
  logic [4:0] fcol;
  logic [7:0] lane_byte;
  logic [1:0] sh_pix;

  always_comb begin
    busy     = (state_q != IDLE);
    run      = (state_q == RUN);
    restart  = pix_ce & line_start;
    step     = pix_ce & busy & ~restart;
    tile_end = step & (p_q == 3'(TILE_W - 1));
    // 31 - c on five bits is the bitwise complement.
    fcol     = c_q[4:0] ^ {5{flip_q}};
    // Rows below the playfield and the slot after column 31 fetch nothing.
    blank    = (row_q >= 5'(PF_ROWS)) | c_q[5];
    fetch_en = busy & (p_q == 3'd0) & ~blank;
    pf_addr  = fetch_en ? {row_q, fcol[4:2]} : 8'h00;
    pf_ce    = fetch_en ? lane_mask(fcol[1:0]) : 4'hF;
    lane_byte = pf_dout[{fcol[1:0], 3'b000} +: 8];
  end

  // Sequencer: phase within tile, fetch column, line parameters.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= 3'd0;
      c_q     <= 6'd0;
      row_q   <= 5'd0;
      line_q  <= 3'd0;
      flip_q  <= 1'b0;
      bank_q  <= 1'b0;
    end else if (restart) begin
      state_q <= PREFETCH;
      p_q     <= 3'd0;
      c_q     <= 6'd0;
      row_q   <= vpos[7:3];
      line_q  <= vpos[2:0] ^ {3{flip}};
      flip_q  <= flip;
      bank_q  <= gfx_bank;
    end else if (step) begin
      p_q <= p_q + 3'd1;
      if (tile_end) begin
        if (state_q == PREFETCH) begin
          state_q <= RUN;
          c_q     <= c_q + 6'd1;
        end else if (c_q == 6'(PF_COLS)) begin
          state_q <= IDLE;
          c_q     <= 6'd0;
        end else begin
          c_q <= c_q + 6'd1;
        end
      end
    end
  end

  // Fetch pipeline: code at p=0, ROM address at p=1, ROM data at p=2.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      code_q      <= 8'h00;
      rom_addr    <= 10'd0;
      pend0_q     <= 8'h00;
      pend1_q     <= 8'h00;
      pend_attr_q <= 2'd0;
      attr_q      <= 2'd0;
    end else if (restart) begin
      pend0_q     <= 8'h00;
      pend1_q     <= 8'h00;
      pend_attr_q <= 2'd0;
      attr_q      <= 2'd0;
    end else if (step) begin
      case (p_q)
        3'd0: code_q <= blank ? 8'h00 : lane_byte;
        3'd1: rom_addr <= {bank_q, code_q[5:0], line_q};
        3'd2: begin
          pend0_q     <= blank ? 8'h00 : rom_d0;
          pend1_q     <= blank ? 8'h00 : rom_d1;
          pend_attr_q <= blank ? 2'd0 : code_q[7:6];
        end
        3'd7: attr_q <= pend_attr_q;
        default: ;
      endcase
    end
  end

  pf_shifter u_shifter (
    .clk_a (clk_a),
    .reset (reset),
    .clear (restart),
    .load  (tile_end),
    .shift (step & ~tile_end),
    .flip  (flip_q),
    .d0    (pend0_q),
    .d1    (pend1_q),
    .pix   (sh_pix)
  );

  always_comb begin
    pix       = run ? sh_pix : 2'd0;
    pix_attr  = run ? attr_q : 2'd0;
    pix_valid = run;
  end

endmodule

// File: tb/tb_pf_tile_fetch.sv
// Self-checking bench for pf_tile_fetch: line-level reference model plus
// directed scenarios with literal expectations.
module tb_pf_tile_fetch;

  logic        clk_a = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  vpos = 8'd0;
  logic        flip = 1'b0;
  logic        gfx_bank = 1'b0;
  logic [7:0]  pf_addr;
  logic [3:0]  pf_ce;
  logic [31:0] pf_dout;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_d0, rom_d1;
  logic [1:0]  pix, pix_attr;
  logic        pix_valid, busy;

  logic [31:0] ram [256];
  logic [7:0]  rom0 [1024];
  logic [7:0]  rom1 [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk_a = ~clk_a;

  assign pf_dout = ram[pf_addr];

  always @(posedge clk_a) begin
    rom_d0 <= rom0[rom_addr];
    rom_d1 <= rom1[rom_addr];
  end

  pf_tile_fetch dut (
    .clk_a      (clk_a),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .vpos       (vpos),
    .flip       (flip),
    .gfx_bank   (gfx_bank),
    .pf_addr    (pf_addr),
    .pf_ce      (pf_ce),
    .pf_dout    (pf_dout),
    .rom_addr   (rom_addr),
    .rom_d0     (rom_d0),
    .rom_d1     (rom_d1),
    .pix        (pix),
    .pix_attr   (pix_attr),
    .pix_valid  (pix_valid),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_active = 1'b0;
  bit         m_rst = 1'b0;
  int         m_e = 0;
  logic [7:0] m_vpos = 8'd0;
  logic       m_flip = 1'b0;
  logic       m_bank = 1'b0;

  function automatic int m_col(input int t);
    return m_flip ? 31 - t : t;
  endfunction

  function automatic logic [7:0] m_code(input int t);
    logic [31:0] w;
    int col;
    col = m_col(t);
    w = ram[{m_vpos[7:3], 3'(col / 4)}];
    return w[8 * (col % 4) +: 8];
  endfunction

  function automatic logic [9:0] m_rom_addr(input int t);
    logic [7:0] code;
    logic [2:0] ln;
    code = m_code(t);
    ln = m_flip ? 3'(7 - int'(m_vpos[2:0])) : m_vpos[2:0];
    return {m_bank, code[5:0], ln};
  endfunction

  // {attr, pix} of pixel k of the current line
  function automatic logic [3:0] m_pixel(input int k);
    logic [7:0] code;
    logic [9:0] a;
    int b;
    if (m_vpos >= 8'd240) return 4'd0;
    code = m_code(k / 8);
    a = m_rom_addr(k / 8);
    b = m_flip ? (k % 8) : (7 - (k % 8));
    return {code[7:6], rom1[a][b], rom0[a][b]};
  endfunction

  always @(posedge clk_a) begin
    logic [3:0] ep;
    logic [3:0] exp_ce;
    logic [7:0] exp_addr;
    int col;
    if (reset) begin
      m_active = 1'b0;
      m_rst = 1'b1;
    end else if (pix_ce && line_start) begin
      m_active = 1'b1;
      m_rst = 1'b0;
      m_e = 0;
      m_vpos = vpos;
      m_flip = flip;
      m_bank = gfx_bank;
    end else if (pix_ce && m_active) begin
      m_e++;
      if (m_e >= 264) m_active = 1'b0;
    end
    #1;
    chk("busy", busy, m_active);
    chk("pix_valid", pix_valid, m_active && m_e >= 8);
    if (m_active && m_e >= 8) begin
      ep = m_pixel(m_e - 8);
      chk("pix", pix, ep[1:0]);
      chk("pix_attr", pix_attr, ep[3:2]);
    end else begin
      chk("pix_idle", pix, 2'd0);
      chk("pix_attr_idle", pix_attr, 2'd0);
    end
    exp_ce = 4'hF;
    exp_addr = 8'h00;
    if (m_active && (m_e % 8) == 0 && (m_e / 8) < 32 && m_vpos < 8'd240) begin
      col = m_col(m_e / 8);
      exp_ce = ~(4'b0001 << (col % 4));
      exp_addr = {m_vpos[7:3], 3'(col / 4)};
    end
    chk("pf_ce", pf_ce, exp_ce);
    chk("pf_addr", pf_addr, exp_addr);
    if (m_active && m_e >= 2 && ((m_e - 2) / 8) < 32 && m_vpos < 8'd240)
      chk("rom_addr", rom_addr, m_rom_addr((m_e - 2) / 8));
    if (m_rst) chk("rom_addr_reset", rom_addr, 10'd0);
  end

  // ---------------- stimulus ----------------
  task automatic pe(input logic ls);
    pix_ce = 1'b1;
    line_start = ls;
    @(posedge clk_a);
    #1;
    pix_ce = 1'b0;
    line_start = 1'b0;
    @(posedge clk_a);
    #1;
  endtask

  task automatic start(input logic [7:0] v, input logic f, input logic b);
    vpos = v;
    flip = f;
    gfx_bank = b;
    pe(1'b1);
  endtask

  task automatic fill_hash();
    for (int i = 0; i < 256; i++) ram[i] = 32'(i * 32'h9E3779B1 + 7);
    for (int i = 0; i < 1024; i++) begin
      rom0[i] = 8'(i * 37 + 11);
      rom1[i] = 8'(i * 91 + 5);
    end
  endtask

  task automatic fill_stripes();
    for (int i = 0; i < 256; i++) ram[i] = 32'(i * 32'h01234567 + 32'h89ABCDEF);
    for (int i = 0; i < 1024; i++) begin
      rom0[i] = 8'hF0;
      rom1[i] = 8'h0F;
    end
  endtask

  initial begin
    int cnt_valid;
    int cnt_ce;
    fill_hash();
    repeat (3) @(posedge clk_a);
    #1;
    reset = 1'b0;
    repeat (4) pe(1'b0);
    chk("idle_busy", busy, 1'b0);

    // Tile 0x45 at column 1, row 0, line 3.
    ram[0][15:8] = 8'h45;
    rom0[10'h02B] = 8'hA5;
    rom1[10'h02B] = 8'h3C;
    start(8'd3, 1'b0, 1'b0);
    for (int e = 1; e <= 270; e++) begin
      pe(1'b0);
      if (e == 8) begin
        chk("t1_pf_addr", pf_addr, 8'h00);
        chk("t1_pf_ce", pf_ce, 4'b1101);
      end
      if (e == 10) chk("t1_rom_addr", rom_addr, 10'h02B);
      if (e >= 16 && e <= 23) chk("t1_attr", pix_attr, 2'd1);
      if (e == 16) chk("t1_pix8", pix, 2'd1);
      if (e == 17) chk("t1_pix9", pix, 2'd0);
      if (e == 18) chk("t1_pix10", pix, 2'd3);
    end

    // Stripe planes, no flip, bank 1.
    fill_stripes();
    cnt_valid = 0;
    start(8'd50, 1'b0, 1'b1);
    for (int e = 1; e <= 270; e++) begin
      pe(1'b0);
      if (pix_valid) cnt_valid++;
      if (e == 7) chk("t2_valid_e7", pix_valid, 1'b0);
      if (e == 8) chk("t2_pix0", pix, 2'd1);
      if (e == 12) chk("t2_pix4", pix, 2'd2);
      if (e == 263) chk("t2_valid_e263", pix_valid, 1'b1);
      if (e == 264) chk("t2_valid_e264", pix_valid, 1'b0);
    end
    chk("t2_valid_count", cnt_valid, 256);

    // Same data flipped.
    start(8'd3, 1'b1, 1'b0);
    chk("t3_pf_addr", pf_addr, 8'h07);
    chk("t3_pf_ce", pf_ce, 4'b0111);
    for (int e = 1; e <= 270; e++) begin
      pe(1'b0);
      if (e == 2) chk("t3_rom_line", rom_addr[2:0], 3'd4);
      if (e == 8) chk("t3_pix0", pix, 2'd2);
      if (e == 12) chk("t3_pix4", pix, 2'd1);
    end

    // Below the playfield: no fetches, blank pixels.
    fill_hash();
    cnt_valid = 0;
    cnt_ce = 0;
    start(8'd245, 1'b0, 1'b0);
    if (pf_ce != 4'hF) cnt_ce++;
    for (int e = 1; e <= 270; e++) begin
      pe(1'b0);
      if (pf_ce != 4'hF) cnt_ce++;
      if (pix_valid) cnt_valid++;
    end
    chk("t4_no_fetch", cnt_ce, 0);
    chk("t4_valid_count", cnt_valid, 256);

    // Restart in the middle of a line.
    start(8'd16, 1'b0, 1'b0);
    for (int e = 1; e <= 108; e++) pe(1'b0);
    chk("t5_valid_before", pix_valid, 1'b1);
    start(8'd80, 1'b0, 1'b1);
    chk("t5_valid_drop", pix_valid, 1'b0);
    chk("t5_busy", busy, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      pe(1'b0);
      if (i == 7) chk("t5_valid_e7", pix_valid, 1'b0);
      if (i == 8) chk("t5_valid_e8", pix_valid, 1'b1);
    end
    for (int e = 9; e <= 270; e++) pe(1'b0);

    // Reset in the middle of RUN.
    start(8'd8, 1'b0, 1'b1);
    for (int e = 1; e <= 50; e++) pe(1'b0);
    reset = 1'b1;
    @(posedge clk_a);
    #1;
    chk("t6_pix", pix, 2'd0);
    chk("t6_attr", pix_attr, 2'd0);
    chk("t6_valid", pix_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_pf_ce", pf_ce, 4'hF);
    chk("t6_pf_addr", pf_addr, 8'h00);
    chk("t6_rom_addr", rom_addr, 10'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) pe(1'b0);
    chk("t6_still_idle", busy, 1'b0);
    chk("t6_rom_addr_hold", rom_addr, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pf_tile_fetch.md
# pf_tile_fetch

Playfield tile fetch and serializer that sits directly downstream of the dual-port playfield RAM read port. For each scanline it reads tile codes from the 32-bit RAM word port and selects the right byte lane. It then fetches the two graphics bitplanes for the current tile line from the playfield graphics ROM and shifts out one 2-bit pixel per pixel enable, with its 2-bit attribute, to the colour mixer.

## Interface
- No parameters. Geometry is fixed: 32 columns x 30 rows of 8x8 tiles.
- clk_a  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- pix_ce  in  1  pixel enable. Asserted at most once every second clk_a cycle.
- line_start  in  1  sampled only with pix_ce; begins fetch of the line given by vpos.
- vpos  in  8  scanline number; sampled with line_start.
- flip  in  1  screen flip; sampled with line_start and held for the whole line.
- gfx_bank  in  1  graphics ROM bank bit; sampled with line_start.
- pf_addr  out  8  playfield RAM word address, {row[4:0], col[4:2]}.
- pf_ce  out  4  active-low byte-lane enable. Exactly one lane is low during a fetch, otherwise 4'hF.
- pf_dout  in  32  RAM word. Combinational read of pf_addr; lane n is bits [8n+7:8n].
- rom_addr  out  10  graphics ROM address, {gfx_bank, code[5:0], line[2:0]}; registered.
- rom_d0, rom_d1  in  8 each  bitplane 0 and bitplane 1. Synchronous ROM, 1 clk_a latency.
- pix  out  2  pixel colour index, {plane1, plane0}.
- pix_attr  out  2  tile code bits [7:6] of the tile being shown.
- pix_valid  out  1  high while the 256 active pixels of a line are output.
- busy  out  1  high in PREFETCH or RUN.

## Operation
- States:
  - IDLE: waits for line_start.
  - PREFETCH: 8 pix_ce steps, fetching column 0.
  - RUN: 256 pix_ce steps, 32 tiles.
- Transitions:
  - IDLE goes to PREFETCH on line_start & pix_ce.
  - PREFETCH goes to RUN after 8 pix_ce.
  - RUN goes to IDLE after 256 pix_ce.
  - line_start & pix_ce in any state restarts PREFETCH with the new vpos. This aborts the current line; the shifters clear and pix_valid drops.
- Coordinates:
  - row = vpos[7:3]; line = vpos[2:0].
  - When flip=1, line is replaced by 7-line and the fetched column by 31-col.
- Phase counter p (3 bits) advances on each pix_ce. The schedule within a tile for fetch column c:
  - p=0: drive pf_addr from c and pull the matching pf_ce lane c[1:0] low. At the pix_ce edge, latch the lane byte into code.
  - p=1: register rom_addr from code.
  - p=2: at the pix_ce edge, capture rom_d0/rom_d1 and code[7:6] into pending registers.
  - p=7: at the pix_ce edge, load the pending registers into the shifters and the attribute register, then increment c. At every other pix_ce edge, shift the shifters by one.
- Shift direction and output bit:
  - flip=0: shift left, pix = {sh1[7], sh0[7]}.
  - flip=1: shift right, pix = {sh1[0], sh0[0]}.
- No fetch is issued in these cases; pf_ce stays 4'hF and the pending registers are forced to 0, giving a blank tile with attr 0:
  - row >= 30 (vpos >= 240).
  - c = 32, the slot during the last tile.
- Column counter c is 6 bits. 32 is the terminal value; there is no wrap into column 0.
- pix_attr changes only at tile boundaries.

## Timing
- Reset: state IDLE, p=0, c=0.
- Output values at reset: pf_addr=0, pf_ce=4'hF, rom_addr=0, pix=0, pix_attr=0, pix_valid=0, busy=0.
- Latency:
  - line_start is sampled at pix_ce edge E0.
  - The shifters load tile 0 at edge E8, and pix_valid rises after E8.
  - Pixel k of the line is on pix after edge E(8+k), for k = 0..255.
  - pix_valid falls after edge E264.
- RAM: pf_addr and pf_ce are stable from the cycle after the p=7 edge (or after E0) through the p=0 pix_ce edge.
- ROM: rom_addr is registered at the p=1 edge. Data is captured at the p=2 edge, which is at least 2 clk_a later.
- Outside RUN: pix=0, pix_attr=0, pix_valid=0.
- reset mid-line: outputs are at their reset values on the next cycle.

## Structure
- Shared package pf_pkg holds:
  - constants PF_COLS=32, PF_ROWS=30, TILE_W=8;
  - the state enum {IDLE, PREFETCH, RUN};
  - the lane-select function (col[1:0] to active-low 4-bit mask).
- One natural sub-module, pf_shifter: a 2-plane, 8-bit load/shift register with a flip direction input.

## Test plan
- Map byte 0x45 in lane 1 of word 0 (column 1, row 0). line_start with vpos=3, flip=0 gives the following, and pixels 8..15 follow the ROM planes MSB first:
  - pf_addr=0 and pf_ce=4'b1101 during the column-1 fetch;
  - rom_addr = {0, 6'h05, 3'd3};
  - pix_attr=1 for pixels 8..15.
- ROM planes 0xF0/0x0F for every tile, flip=0. Per 8-pixel group, pix=1 for 4 pixels then 2 for 4 pixels. pix_valid is high exactly 256 pix_ce, starting after edge E8.
- Same data with flip=1 and vpos=3:
  - column 31 is fetched first;
  - rom_addr line field = 4;
  - each group outputs pix=2 for 4 pixels, then 1 for 4 pixels.
- vpos=245: pf_ce stays 4'hF for the whole line; pix=0 and pix_attr=0 for all 256 pixels; pix_valid still pulses.
- line_start at pixel 100 of a RUN line: pix_valid drops and PREFETCH restarts. The next valid pixel appears 8 pix_ce later, from column 0 of the new vpos.
- reset asserted mid-RUN: all outputs are at their reset values on the next cycle. No activity until line_start.
